// File: rtl/gaussian_result_pkg.sv
// Shared types, constants and the saturating adder used by gaussian_result_serializer.
package gaussian_result_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  localparam int NUM_CH   = 5;
  localparam int X_CH_DEF = 1;
  localparam int Y_CH_DEF = 2;

  // Operands are sign-extended width-bit values, so the 64-bit sum is exact before clamping.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v) begin
      return max_v;
    end
    if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/gaussian_result_hold.sv
// One-word holding register for a single CNN output channel, with ready generation
// and a saturating offset applied on capture.
module gaussian_result_hold
  import gaussian_result_pkg::*;
#(
  parameter int W      = 16,
  parameter int OFFSET = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         accept_en,
  input  logic         clear,
  input  logic [W-1:0] in_tdata,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [W-1:0] word,
  output logic         full,
  output logic         full_next
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;
  logic         full_q;
  logic         full_d;
  logic [W-1:0] adj;
  logic         take;

  if (OFFSET != 0) begin : g_add
    assign adj = W'(sat_add(64'(signed'(in_tdata)), 64'(OFFSET), W));
  end else begin : g_pass
    assign adj = in_tdata;
  end

  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    in_tready = accept_en & ~full_q;
    take      = in_tready & in_tvalid;
    word_d    = word_q;
    full_d    = full_q;
    if (take) begin
      word_d = adj;
      full_d = 1'b1;
    end
    if (clear) begin
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // NOTE: the data register is deliberately not reset; full_q alone says whether it holds a word.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word      = word_q;
  assign full      = full_q;
  assign full_next = full_d;

endmodule

// File: rtl/gaussian_result_serializer.sv
// Gathers one word from each of the five CNN output streams, shifts the centre
// coordinates to full-image space, and emits them as one 5-word packet with TLAST.
module gaussian_result_serializer
  import gaussian_result_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int Y_1             = 10,
  parameter int X_1             = 10,
  parameter int X_CH            = X_CH_DEF,
  parameter int Y_CH            = Y_CH_DEF
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_0_TDATA,
  input  logic                       cnn_output_0_TVALID,
  output logic                       cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_1_TDATA,
  input  logic                       cnn_output_1_TVALID,
  output logic                       cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_2_TDATA,
  input  logic                       cnn_output_2_TVALID,
  output logic                       cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_3_TDATA,
  input  logic                       cnn_output_3_TVALID,
  output logic                       cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_4_TDATA,
  input  logic                       cnn_output_4_TVALID,
  output logic                       cnn_output_4_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] result_TDATA,
  output logic                       result_TVALID,
  input  logic                       result_TREADY,
  output logic                       result_TLAST,
  output logic [31:0]                packet_count,
  output logic                       busy
);

  localparam int                 IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CH - 1);

  logic [PIXEL_BIT_WIDTH-1:0] ch_tdata [NUM_CH];
  logic [PIXEL_BIT_WIDTH-1:0] word     [NUM_CH];
  logic [NUM_CH-1:0]          ch_tvalid;
  logic [NUM_CH-1:0]          ch_tready;
  logic [NUM_CH-1:0]          full;
  logic [NUM_CH-1:0]          full_next;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [31:0]        packet_count_q, packet_count_d;
  logic               armed_q, armed_d;
  logic               accept_en;
  logic               clear;
  logic               is_last;

  assign ch_tdata[0] = cnn_output_0_TDATA;
  assign ch_tdata[1] = cnn_output_1_TDATA;
  assign ch_tdata[2] = cnn_output_2_TDATA;
  assign ch_tdata[3] = cnn_output_3_TDATA;
  assign ch_tdata[4] = cnn_output_4_TDATA;
  assign ch_tvalid   = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                        cnn_output_1_TVALID, cnn_output_0_TVALID};

  assign cnn_output_0_TREADY = ch_tready[0];
  assign cnn_output_1_TREADY = ch_tready[1];
  assign cnn_output_2_TREADY = ch_tready[2];
  assign cnn_output_3_TREADY = ch_tready[3];
  assign cnn_output_4_TREADY = ch_tready[4];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    gaussian_result_hold #(
      .W      (PIXEL_BIT_WIDTH),
      .OFFSET ((k == X_CH) ? X_1 : ((k == Y_CH) ? Y_1 : 0))
    ) u_hold (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .accept_en (accept_en),
      .clear     (clear),
      .in_tdata  (ch_tdata[k]),
      .in_tvalid (ch_tvalid[k]),
      .in_tready (ch_tready[k]),
      .word      (word[k]),
      .full      (full[k]),
      .full_next (full_next[k])
    );
  end

  assign is_last = (out_idx_q == LAST_IDX);
  // Inputs stay blocked for the first cycle after reset, then open permanently.
  assign armed_d = 1'b1;

  always_comb begin
    state_d        = state_q;
    out_idx_d      = out_idx_q;
    packet_count_d = packet_count_q;
    accept_en      = 1'b0;
    clear          = 1'b0;
    result_TVALID  = 1'b0;
    result_TLAST   = 1'b0;
    result_TDATA   = '0;
    unique case (state_q)
      COLLECT: begin
        accept_en = armed_q;
        if (&full_next) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        result_TVALID = 1'b1;
        result_TDATA  = word[out_idx_q];
        result_TLAST  = is_last;
        if (result_TREADY) begin
          if (is_last) begin
            out_idx_d      = '0;
            clear          = 1'b1;
            packet_count_d = packet_count_q + 32'd1;
            state_d        = COLLECT;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= COLLECT;
      out_idx_q      <= '0;
      packet_count_q <= '0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_idx_q      <= out_idx_d;
      packet_count_q <= packet_count_d;
      armed_q        <= armed_d;
    end
  end

  assign packet_count = packet_count_q;
  assign busy         = (state_q == EMIT) | (|full);

endmodule

// File: tb/tb_gaussian_result_serializer.sv
// Directed and randomized bench for gaussian_result_serializer against a queue-based packet model.
module tb_gaussian_result_serializer;

  localparam int W     = 16;
  localparam int NCH   = 5;
  localparam int X_OFF = 10;
  localparam int Y_OFF = 10;
  localparam int XC    = 1;
  localparam int YC    = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [W-1:0]  in_data [NCH];
  logic [NCH-1:0] in_valid;
  wire  [NCH-1:0] in_ready;
  logic [W-1:0]  result_TDATA;
  logic          result_TVALID;
  logic          result_TREADY;
  logic          result_TLAST;
  logic [31:0]   packet_count;
  logic          busy;

  always #5 ap_clk = ~ap_clk;

  gaussian_result_serializer #(
    .PIXEL_BIT_WIDTH (W),
    .Y_1             (Y_OFF),
    .X_1             (X_OFF),
    .X_CH            (XC),
    .Y_CH            (YC)
  ) dut (
    .ap_clk              (ap_clk),
    .ap_rst              (ap_rst),
    .cnn_output_0_TDATA  (in_data[0]),
    .cnn_output_0_TVALID (in_valid[0]),
    .cnn_output_0_TREADY (in_ready[0]),
    .cnn_output_1_TDATA  (in_data[1]),
    .cnn_output_1_TVALID (in_valid[1]),
    .cnn_output_1_TREADY (in_ready[1]),
    .cnn_output_2_TDATA  (in_data[2]),
    .cnn_output_2_TVALID (in_valid[2]),
    .cnn_output_2_TREADY (in_ready[2]),
    .cnn_output_3_TDATA  (in_data[3]),
    .cnn_output_3_TVALID (in_valid[3]),
    .cnn_output_3_TREADY (in_ready[3]),
    .cnn_output_4_TDATA  (in_data[4]),
    .cnn_output_4_TVALID (in_valid[4]),
    .cnn_output_4_TREADY (in_ready[4]),
    .result_TDATA        (result_TDATA),
    .result_TVALID       (result_TVALID),
    .result_TREADY       (result_TREADY),
    .result_TLAST        (result_TLAST),
    .packet_count        (packet_count),
    .busy                (busy)
  );

  typedef logic [W-1:0] word_q_t[$];
  word_q_t        ch_q [NCH];
  int             out_pos;
  int             pkts_model;
  bit             fresh;
  logic [NCH-1:0] acc;
  logic [W-1:0]   got [8];
  int             ngot;
  int             n_vec;
  int             n_err;

  function automatic logic [W-1:0] adjust(input int k, input logic [W-1:0] d);
    int v;
    v = int'($signed(d));
    if (k == XC) v += X_OFF;
    else if (k == YC) v += Y_OFF;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 16'h7FF0 | 16'($urandom_range(0, 15));
      1:       return 16'h8000 | 16'($urandom_range(0, 15));
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate the handshakes the coming rising edge will commit, then advance to the next falling edge.
  task automatic step();
    bit             all_held;
    bit             any_held;
    bit             emitting;
    logic [NCH-1:0] exp_ready;
    logic [W-1:0]   w;
    #1;
    all_held = 1'b1;
    any_held = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q[k].size() == 0) all_held = 1'b0;
      else any_held = 1'b1;
    end
    emitting = (out_pos != 0) || all_held;
    for (int k = 0; k < NCH; k++) exp_ready[k] = !fresh && !emitting && (ch_q[k].size() == 0);
    chk("res_valid", 32'(result_TVALID), 32'(emitting));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(any_held));
    chk("pkt_count", packet_count, 32'(pkts_model));
    if (result_TVALID && result_TREADY) begin
      chk("held_word", 32'(ch_q[out_pos].size()), 32'd1);
      if (ch_q[out_pos].size() != 0) begin
        w = ch_q[out_pos].pop_front();
        chk("res_data", 32'(result_TDATA), 32'(adjust(out_pos, w)));
      end
      chk("res_last", 32'(result_TLAST), 32'(out_pos == NCH - 1));
      if (ngot < 8) got[ngot] = result_TDATA;
      ngot++;
      out_pos++;
      if (out_pos == NCH) begin
        out_pos = 0;
        pkts_model++;
      end
    end
    acc = in_valid & in_ready;
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        chk("no_overwrite", 32'(ch_q[k].size()), 32'd0);
        ch_q[k].push_back(in_data[k]);
      end
    end
    fresh = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic do_reset(input int cycles);
    ap_rst        = 1'b1;
    in_valid      = '0;
    result_TREADY = 1'b0;
    repeat (cycles) @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int k = 0; k < NCH; k++) ch_q[k].delete();
    out_pos    = 0;
    pkts_model = 0;
    fresh      = 1'b1;
  endtask

  task automatic capture(input logic [W-1:0] d0, d1, d2, d3, d4);
    in_data[0] = d0; in_data[1] = d1; in_data[2] = d2; in_data[3] = d3; in_data[4] = d4;
    in_valid = '1;
    step();
    in_valid = '0;
  endtask

  task automatic drain_packet(input int budget);
    int target;
    int n;
    target        = pkts_model + 1;
    n             = 0;
    ngot          = 0;
    result_TREADY = 1'b1;
    while (pkts_model < target && n < budget) begin
      step();
      n++;
    end
    result_TREADY = 1'b0;
    chk("drain_count", packet_count, 32'(target));
  endtask

  initial begin
    int order [NCH];
    logic [W-1:0] hold_data;
    logic hold_last;
    logic [W-1:0] d0;
    int guard;

    n_vec = 0; n_err = 0; ngot = 0; acc = '0;
    for (int k = 0; k < NCH; k++) in_data[k] = '0;

    // Reset state
    do_reset(2);
    chk("rst_valid", 32'(result_TVALID), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", packet_count, 32'd0);
    step();

    // Simultaneous arrival
    capture(16'd100, 16'd20, 16'd30, 16'd40, 16'd50);
    chk("t1_latency", 32'(result_TVALID), 32'd1);
    drain_packet(40);
    chk("t1_w0", 32'(got[0]), 32'd100);
    chk("t1_w1", 32'(got[1]), 32'd30);
    chk("t1_w2", 32'(got[2]), 32'd40);
    chk("t1_w3", 32'(got[3]), 32'd40);
    chk("t1_w4", 32'(got[4]), 32'd50);
    chk("t1_count", packet_count, 32'd1);

    // Staggered arrival, order 4,0,3,2,1
    order = '{4, 0, 3, 2, 1};
    for (int j = 0; j < NCH; j++) begin
      in_data[order[j]]  = rand_word();
      in_valid[order[j]] = 1'b1;
      step();
      in_valid[order[j]] = 1'b0;
      chk("t2_ready_drop", 32'(in_ready[order[j]]), 32'd0);
      if (j < NCH - 1) repeat (9) step();
    end
    chk("t2_valid", 32'(result_TVALID), 32'd1);
    drain_packet(40);

    // Saturation on x, plain offset on y
    capture(16'h0000, 16'h7FFA, 16'h8000, 16'h0000, 16'h0000);
    drain_packet(40);
    chk("t3_x_sat", 32'(got[1]), 32'h7FFF);
    chk("t3_y_off", 32'(got[2]), 32'h800A);

    // Backpressure at out_idx 2
    capture(rand_word(), rand_word(), rand_word(), rand_word(), rand_word());
    result_TREADY = 1'b1;
    repeat (2) step();
    result_TREADY = 1'b0;
    hold_data = result_TDATA;
    hold_last = result_TLAST;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_data_stable", 32'(result_TDATA), 32'(hold_data));
      chk("t4_last_stable", 32'(result_TLAST), 32'(hold_last));
      chk("t4_in_blocked", 32'(in_ready), 32'd0);
    end
    drain_packet(40);
    chk("t4_words_left", 32'(ngot), 32'd3);

    // Reset after three emitted words
    capture(rand_word(), rand_word(), rand_word(), rand_word(), rand_word());
    result_TREADY = 1'b1;
    repeat (3) step();
    do_reset(1);
    chk("t5_valid", 32'(result_TVALID), 32'd0);
    chk("t5_count", packet_count, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    step();
    d0 = rand_word();
    capture(d0, rand_word(), rand_word(), rand_word(), rand_word());
    drain_packet(40);
    chk("t5_first_word", 32'(got[0]), 32'(d0));

    // Randomized traffic, 1000 packets
    do_reset(2);
    step();
    guard = 0;
    while (pkts_model < 1000 && guard < 60000) begin
      for (int k = 0; k < NCH; k++) begin
        if (in_valid[k] && acc[k]) in_valid[k] = 1'b0;
        if (!in_valid[k] && $urandom_range(0, 1) == 1) begin
          in_valid[k] = 1'b1;
          in_data[k]  = rand_word();
        end
      end
      result_TREADY = ($urandom_range(0, 2) != 0);
      step();
      guard++;
    end
    chk("rand_pkts", packet_count, 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
